// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer.
//   led_mode_t      : pattern engine modes as loaded over the config handshake
//   led_state_t     : control FSM states (RUN accepts configs, APPLY loads them)
//   led_dir_t       : travel direction used by the bounce mode
//   DEFAULT_PATTERN : display value used at reset and whenever a zero pattern is loaded
package led_pkg;

   typedef enum logic [2:0] {
      MODE_OFF    = 3'd0,
      MODE_ROT_L  = 3'd1,
      MODE_ROT_R  = 3'd2,
      MODE_BOUNCE = 3'd3,
      MODE_BLINK  = 3'd4,
      MODE_COUNT  = 3'd5,
      MODE_STATIC = 3'd6,
      MODE_RSVD   = 3'd7
   } led_mode_t;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_APPLY = 1'b1
   } led_state_t;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } led_dir_t;

   localparam logic [7:0] DEFAULT_PATTERN = 8'h01;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Configuration handshake between the host control logic and the sequencer.
//   cfg_valid   : host presents a configuration
//   cfg_ready   : sequencer can accept a configuration
//   cfg_mode    : pattern mode (led_pkg::led_mode_t encoding)
//   cfg_pattern : initial display pattern
//   cfg_bright  : brightness, 0 = dark, all-ones = fully on
// master = host side, slave = sequencer side.
interface led_pattern_sequencer_if #(
   parameter int PWM_WIDTH = 4
);
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [2:0]           cfg_mode;
   logic [7:0]           cfg_pattern;
   logic [PWM_WIDTH-1:0] cfg_bright;

   modport master (
      output cfg_valid, cfg_mode, cfg_pattern, cfg_bright,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_mode, cfg_pattern, cfg_bright,
      output cfg_ready
   );
endinterface

// File: rtl/led_step_prescaler.sv
// Free-running step prescaler: one tick every 2^PRESCALE_WIDTH clocks.
//   CLK   : system clock
//   RST   : asynchronous active-high reset
//   clear : hold the count at zero and suppress the tick
//   tick  : high for the single cycle in which the count is all-ones
module led_step_prescaler #(
   parameter int PRESCALE_WIDTH = 27
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear,
   output logic tick
);
   logic [PRESCALE_WIDTH-1:0] count_reg;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
      end
   end

   // Decoded from the registered count, so the pulse is clean and lines up
   // with the edge on which the step is applied.
   assign tick = (&count_reg) && !clear;
endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer for the 8-LED PMod.
//   CLK       : system clock, all state on rising edge
//   RST       : asynchronous active-high reset
//   cfg       : configuration handshake (slave side)
//   step_tick : one-cycle pulse on each pattern step
//   LED       : registered, PWM-dimmed LED drive
// A config is captured in RUN and loaded in a one-cycle APPLY state; the
// prescaler advances the pattern and a PWM stage gates the final output.
module led_pattern_sequencer
   import led_pkg::*;
#(
   parameter int PRESCALE_WIDTH = 27,
   parameter int PWM_WIDTH      = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   led_pattern_sequencer_if.slave  cfg,
   output logic                    step_tick,
   output logic [7:0]              LED
);
   led_state_t           state_reg;
   led_mode_t            mode_reg;
   led_mode_t            cap_mode_reg;
   led_dir_t             dir_reg;
   logic [7:0]           display_reg;
   logic [7:0]           cap_pattern_reg;
   logic                 blink_phase_reg;
   logic                 ready_reg;
   logic [PWM_WIDTH-1:0] bright_reg;
   logic [PWM_WIDTH-1:0] cap_bright_reg;
   logic [PWM_WIDTH-1:0] pwm_cnt_reg;
   logic [7:0]           led_reg;

   logic [7:0]           display_next;
   led_dir_t             dir_next;
   logic                 blink_phase_next;
   logic [7:0]           pre_pwm;
   logic                 pwm_enable;

   led_step_prescaler #(
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) u_prescaler (
      .CLK  (CLK),
      .RST  (RST),
      .clear(state_reg == ST_APPLY),
      .tick (step_tick)
   );

   // State the pattern engine moves to if a step is taken this cycle.
   always_comb begin
      display_next     = display_reg;
      dir_next         = dir_reg;
      blink_phase_next = blink_phase_reg;
      case (mode_reg)
         MODE_ROT_L: display_next = {display_reg[6:0], display_reg[7]};
         MODE_ROT_R: display_next = {display_reg[0], display_reg[7:1]};
         MODE_BOUNCE: begin
            // Turn around when the lit bit reaches the end it is heading for.
            if (dir_reg == DIR_LEFT && display_reg[7]) begin
               dir_next     = DIR_RIGHT;
               display_next = display_reg >> 1;
            end else if (dir_reg == DIR_RIGHT && display_reg[0]) begin
               dir_next     = DIR_LEFT;
               display_next = display_reg << 1;
            end else if (dir_reg == DIR_LEFT) begin
               display_next = display_reg << 1;
            end else begin
               display_next = display_reg >> 1;
            end
         end
         MODE_BLINK: blink_phase_next = ~blink_phase_reg;
         MODE_COUNT: display_next = display_reg + 8'd1;
         default:    ;
      endcase
   end

   always_comb begin
      pre_pwm = 8'h00;
      case (mode_reg)
         MODE_ROT_L, MODE_ROT_R, MODE_BOUNCE,
         MODE_COUNT, MODE_STATIC: pre_pwm = display_reg;
         MODE_BLINK:              pre_pwm = blink_phase_reg ? display_reg : 8'h00;
         default:                 pre_pwm = 8'h00;
      endcase
   end

   // All-ones brightness must be on every cycle, which the compare alone misses.
   assign pwm_enable = (&bright_reg) || (pwm_cnt_reg < bright_reg);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg       <= ST_RUN;
         ready_reg       <= 1'b1;
         mode_reg        <= MODE_OFF;
         cap_mode_reg    <= MODE_OFF;
         dir_reg         <= DIR_LEFT;
         display_reg     <= DEFAULT_PATTERN;
         cap_pattern_reg <= DEFAULT_PATTERN;
         blink_phase_reg <= 1'b0;
         bright_reg      <= '1;
         cap_bright_reg  <= '1;
         pwm_cnt_reg     <= '0;
         led_reg         <= 8'h00;
      end else begin
         pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
         led_reg     <= pre_pwm & {8{pwm_enable}};
         case (state_reg)
            ST_RUN: begin
               // A tick coinciding with a handshake still steps; APPLY then
               // overwrites that result on the following edge.
               if (step_tick) begin
                  display_reg     <= display_next;
                  dir_reg         <= dir_next;
                  blink_phase_reg <= blink_phase_next;
               end
               if (cfg.cfg_valid && ready_reg) begin
                  cap_mode_reg    <= led_mode_t'(cfg.cfg_mode);
                  cap_pattern_reg <= cfg.cfg_pattern;
                  cap_bright_reg  <= cfg.cfg_bright;
                  ready_reg       <= 1'b0;
                  state_reg       <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               display_reg     <= (cap_pattern_reg == 8'h00) ? DEFAULT_PATTERN : cap_pattern_reg;
               mode_reg        <= cap_mode_reg;
               bright_reg      <= cap_bright_reg;
               dir_reg         <= DIR_LEFT;
               blink_phase_reg <= 1'b0;
               ready_reg       <= 1'b1;
               state_reg       <= ST_RUN;
            end
            default: state_reg <= ST_RUN;
         endcase
      end
   end

   assign cfg.cfg_ready = ready_reg;
   assign LED           = led_reg;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed testbench for led_pattern_sequencer with PRESCALE_WIDTH=4, PWM_WIDTH=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_led_pattern_sequencer;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       step_tick;
   logic [7:0] LED;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   led_pattern_sequencer_if #(.PWM_WIDTH(4)) cfg_if ();

   led_pattern_sequencer #(
      .PRESCALE_WIDTH(4),
      .PWM_WIDTH     (4)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .cfg      (cfg_if),
      .step_tick(step_tick),
      .LED      (LED)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   // Handshake one configuration; returns two edges later, once the new
   // display has reached LED.
   task automatic configure(input logic [2:0] m, input logic [7:0] p, input logic [3:0] b);
      $display("config: mode=%0d pattern=%02h bright=%0h", m, p, b);
      check("cfg_ready_idle", cfg_if.cfg_ready, 1);
      cfg_if.cfg_valid   = 1'b1;
      cfg_if.cfg_mode    = m;
      cfg_if.cfg_pattern = p;
      cfg_if.cfg_bright  = b;
      cycle();
      cfg_if.cfg_valid = 1'b0;
      check("cfg_ready_apply", cfg_if.cfg_ready, 0);
      check("tick_in_apply", step_tick, 0);
      cycle();
      check("cfg_ready_back", cfg_if.cfg_ready, 1);
      cycle();
   endtask

   task automatic wait_tick(output int at);
      int n = 0;
      while (step_tick !== 1'b1 && n < 40) begin
         cycle();
         n++;
      end
      if (step_tick !== 1'b1) check("tick_timeout", step_tick, 1);
      at = cyc;
   endtask

   // Wait for a step, then look at LED once the stepped display has propagated.
   task automatic next_step_led(input string tag, input logic [7:0] exp);
      int t;
      wait_tick(t);
      cycle();
      cycle();
      check(tag, LED, exp);
      $display("step: %s LED=%02h", tag, LED);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t0, t1, t2;
      logic [7:0] bounce_seq [15];

      cfg_if.cfg_valid   = 1'b0;
      cfg_if.cfg_mode    = 3'd0;
      cfg_if.cfg_pattern = 8'h00;
      cfg_if.cfg_bright  = 4'h0;

      repeat (3) cycle();
      check("rst_led", LED, 0);
      check("rst_ready", cfg_if.cfg_ready, 1);
      check("rst_tick", step_tick, 0);
      RST = 1'b0;

      // Idle in mode OFF: LED dark, ready high, prescaler still free-running.
      n = 0;
      for (int i = 0; i < 64; i++) begin
         cycle();
         check("idle_led", LED, 0);
         check("idle_ready", cfg_if.cfg_ready, 1);
         if (step_tick) n++;
      end
      check("idle_tick_count", n, 4);

      // Rotate left from 80.
      configure(3'd1, 8'h80, 4'hF);
      t0 = cyc;
      check("rotl_first", LED, 8'h80);
      wait_tick(t1);
      check("first_tick_latency", t1 - t0, 14);
      check("rotl_hold", LED, 8'h80);
      cycle();
      cycle();
      check("rotl_wrap", LED, 8'h01);
      wait_tick(t2);
      check("tick_spacing", t2 - t1, 16);
      cycle();
      cycle();
      check("rotl_second", LED, 8'h02);

      // Rotate right.
      configure(3'd2, 8'h01, 4'hF);
      check("rotr_first", LED, 8'h01);
      next_step_led("rotr_1", 8'h80);
      next_step_led("rotr_2", 8'h40);

      // Bounce across the full width and back.
      bounce_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                     8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      configure(3'd3, 8'h01, 4'hF);
      check("bounce_first", LED, 8'h01);
      for (int i = 0; i < 15; i++) next_step_led("bounce", bounce_seq[i]);

      // Counter wraps FF -> 00.
      configure(3'd5, 8'hFE, 4'hF);
      check("count_first", LED, 8'hFE);
      next_step_led("count_1", 8'hFF);
      next_step_led("count_2", 8'h00);
      next_step_led("count_3", 8'h01);

      // Blink starts dark.
      configure(3'd4, 8'h3C, 4'hF);
      check("blink_first", LED, 8'h00);
      next_step_led("blink_1", 8'h3C);
      next_step_led("blink_2", 8'h00);

      // OFF and reserved keep LED dark.
      configure(3'd0, 8'hAA, 4'hF);
      check("off_first", LED, 8'h00);
      next_step_led("off_step", 8'h00);
      configure(3'd7, 8'h55, 4'hF);
      check("rsvd_first", LED, 8'h00);
      next_step_led("rsvd_step", 8'h00);

      // Zero pattern loads the default.
      configure(3'd6, 8'h00, 4'hF);
      check("zero_pattern", LED, 8'h01);
      next_step_led("static_hold", 8'h01);

      // PWM duty over one 16-cycle frame.
      configure(3'd6, 8'hFF, 4'h4);
      n = 0;
      for (int i = 0; i < 16; i++) begin
         cycle();
         if (LED == 8'hFF) n++;
         else check("pwm_off_value", LED, 0);
      end
      check("pwm_duty_4", n, 4);

      configure(3'd6, 8'hFF, 4'h1);
      n = 0;
      for (int i = 0; i < 16; i++) begin
         cycle();
         if (LED == 8'hFF) n++;
      end
      check("pwm_duty_1", n, 1);

      configure(3'd6, 8'hFF, 4'hE);
      n = 0;
      for (int i = 0; i < 16; i++) begin
         cycle();
         if (LED == 8'hFF) n++;
      end
      check("pwm_duty_14", n, 14);

      configure(3'd6, 8'hFF, 4'h0);
      n = 0;
      for (int i = 0; i < 32; i++) begin
         cycle();
         if (LED != 8'h00) n++;
      end
      check("pwm_dark", n, 0);

      // Asynchronous reset between edges during bounce.
      configure(3'd3, 8'h01, 4'hF);
      next_step_led("bounce_pre_rst", 8'h02);
      #3;
      RST = 1'b1;
      #1;
      check("async_rst_led", LED, 0);
      check("async_rst_ready", cfg_if.cfg_ready, 1);
      check("async_rst_tick", step_tick, 0);
      cycle();
      RST = 1'b0;
      check("post_rst_led", LED, 0);

      // A second request held during APPLY must not be taken.
      $display("config: mode=1 pattern=81 bright=f, then mode=5 pattern=10 during APPLY");
      cfg_if.cfg_valid   = 1'b1;
      cfg_if.cfg_mode    = 3'd1;
      cfg_if.cfg_pattern = 8'h81;
      cfg_if.cfg_bright  = 4'hF;
      cycle();
      cfg_if.cfg_mode    = 3'd5;
      cfg_if.cfg_pattern = 8'h10;
      check("apply_ready_low", cfg_if.cfg_ready, 0);
      cycle();
      cfg_if.cfg_valid = 1'b0;
      cycle();
      check("apply_ignored_led", LED, 8'h81);
      check("apply_ignored_ready", cfg_if.cfg_ready, 1);
      next_step_led("apply_ignored_step", 8'h03);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
